// File: rtl/jesd204b_pkg.sv
// Shared definitions for the JESD204B data-link transmit controller: link state
// encoding, ILAS length and configuration legality checks.
package jesd204b_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CGS  = 2'd1,
        ST_ILAS = 2'd2,
        ST_DATA = 2'd3
    } link_state_e;

    localparam int ILAS_MF = 4;
    // Beat counter covers up to 32 beats per multiframe (F*K <= 128).
    localparam int BEAT_W  = 6;
    localparam int OCT_W   = 3;

    function automatic bit f_legal(input int f);
        return (f >= 1) && (f <= 8);
    endfunction

    function automatic bit fk_legal(input int f, input int k);
        return f_legal(f) && (k >= 1) && ((f * k) % 4 == 0) && (f * k <= 128);
    endfunction

    function automatic bit resync_legal(input int rb);
        return (rb >= 2) && (rb <= 255);
    endfunction

endpackage

// File: rtl/jesd204b_lmfc_gen.sv
// LMFC and per-octet frame/multiframe boundary generator. Flags are registered
// from the next-beat position so lmfc, eof and eom always describe the same beat.
module jesd204b_lmfc_gen
    import jesd204b_pkg::*;
#(
    parameter int F = 5,
    parameter int K = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sysref_i,
    input  logic       sysref_oneshot_i,
    output logic       realign_o,
    output logic       lmfc_next_o,
    output logic       lmfc_o,
    output logic [3:0] eof_o,
    output logic [3:0] eom_o
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(F * K / 4 - 1);
    localparam logic [OCT_W-1:0]  LAST_OCT  = OCT_W'(F - 1);

    logic              sysref_q;
    logic              seen_q;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [OCT_W-1:0]  oif_q, oif_d;
    logic              lmfc_q;
    logic [3:0]        eof_q, eof_d, eom_q, eom_d;
    logic              sysref_edge;

    // Walk the octet-in-frame counter across the four octets of a beat.
    function automatic logic [OCT_W-1:0] oif_after_beat(input logic [OCT_W-1:0] start);
        logic [OCT_W-1:0] p;
        p = start;
        for (int i = 0; i < 4; i++) begin
            p = (p == LAST_OCT) ? '0 : p + OCT_W'(1);
        end
        return p;
    endfunction

    function automatic logic [3:0] eof_flags(input logic [OCT_W-1:0] start);
        logic [OCT_W-1:0] p;
        logic [3:0]       flags;
        p     = start;
        flags = '0;
        for (int i = 0; i < 4; i++) begin
            flags[i] = (p == LAST_OCT);
            p = (p == LAST_OCT) ? '0 : p + OCT_W'(1);
        end
        return flags;
    endfunction

    assign sysref_edge = sysref_i && !sysref_q;
    assign realign_o   = sysref_edge && !(sysref_oneshot_i && seen_q);

    always_comb begin
        beat_d = beat_q + BEAT_W'(1);
        oif_d  = oif_after_beat(oif_q);
        if (realign_o || (beat_q == LAST_BEAT)) begin
            beat_d = '0;
            oif_d  = '0;
        end
    end

    assign eof_d       = eof_flags(oif_d);
    assign eom_d       = (beat_d == LAST_BEAT) ? 4'b1000 : 4'b0000;
    assign lmfc_next_o = (beat_d == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sysref_q <= 1'b0;
            seen_q   <= 1'b0;
            beat_q   <= '0;
            oif_q    <= '0;
            lmfc_q   <= 1'b0;
            eof_q    <= '0;
            eom_q    <= '0;
        end else begin
            sysref_q <= sysref_i;
            seen_q   <= seen_q || sysref_edge;
            beat_q   <= beat_d;
            oif_q    <= oif_d;
            lmfc_q   <= lmfc_next_o;
            eof_q    <= eof_d;
            eom_q    <= eom_d;
        end
    end

    assign lmfc_o = lmfc_q;
    assign eof_o  = eof_q;
    assign eom_o  = eom_q;

endmodule

// File: rtl/jesd204b_dl_tx_ctrl.sv
// JESD204B transmit data-link controller: CGS/ILAS/DATA sequencing against the
// local multiframe clock, plus SYNC~ resync and short-pulse error monitoring.
module jesd204b_dl_tx_ctrl
    import jesd204b_pkg::*;
#(
    parameter int OCTETS_PER_FR = 5,
    parameter int FRAMES_PER_MF = 4,
    parameter int RESYNC_BEATS  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        link_en,
    input  logic        sync_n,
    input  logic        sysref,
    input  logic        sysref_oneshot,
    output logic        lmfc,
    output logic        cgs_en,
    output logic        ilas_en,
    output logic        data_en,
    output logic [1:0]  ilas_mf,
    output logic [3:0]  eof,
    output logic [3:0]  eom,
    output logic        link_up,
    output logic [7:0]  sync_err_cnt,
    output link_state_e state_o
);

    if (!fk_legal(OCTETS_PER_FR, FRAMES_PER_MF) || !resync_legal(RESYNC_BEATS)) begin : g_cfg_check
        $error("jesd204b_dl_tx_ctrl: illegal OCTETS_PER_FR/FRAMES_PER_MF/RESYNC_BEATS");
    end

    localparam logic [7:0] RB = 8'(RESYNC_BEATS);

    link_state_e state_q, state_d;
    logic [1:0]  ilas_mf_q, ilas_mf_d;
    logic        cgs_en_q, ilas_en_q, data_en_q;
    logic [7:0]  low_cnt_q, low_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        resync, short_pulse;
    logic        realign, lmfc_next;

    jesd204b_lmfc_gen #(
        .F (OCTETS_PER_FR),
        .K (FRAMES_PER_MF)
    ) u_lmfc_gen (
        .clk              (clk),
        .reset_n          (reset_n),
        .sysref_i         (sysref),
        .sysref_oneshot_i (sysref_oneshot),
        .realign_o        (realign),
        .lmfc_next_o      (lmfc_next),
        .lmfc_o           (lmfc),
        .eof_o            (eof),
        .eom_o            (eom)
    );

    // low_cnt saturates at RB, so a value below RB on the rising edge is a short pulse.
    always_comb begin
        low_cnt_d = low_cnt_q;
        if (sync_n) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != RB) begin
            low_cnt_d = low_cnt_q + 8'd1;
        end
        resync      = !sync_n && (low_cnt_q >= RB - 8'd1);
        short_pulse = sync_n && (low_cnt_q != 8'd0) && (low_cnt_q < RB) && (state_q == ST_DATA);
        err_cnt_d   = err_cnt_q;
        if (short_pulse && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ilas_mf_d = ilas_mf_q;
        case (state_q)
            ST_IDLE: state_d = ST_CGS;
            ST_CGS: begin
                if (sync_n && lmfc_next) begin
                    state_d = ST_ILAS;
                end
            end
            ST_ILAS: begin
                if (realign || resync) begin
                    state_d = ST_CGS;
                end else if (lmfc_next) begin
                    if (ilas_mf_q == 2'(ILAS_MF - 1)) begin
                        state_d = ST_DATA;
                    end else begin
                        ilas_mf_d = ilas_mf_q + 2'd1;
                    end
                end
            end
            ST_DATA: begin
                if (resync) begin
                    state_d = ST_CGS;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!link_en) begin
            state_d = ST_IDLE;
        end
        // ILAS always begins at multiframe 0, whichever way it is entered.
        if ((state_d != ST_ILAS) || (state_q != ST_ILAS)) begin
            ilas_mf_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ilas_mf_q <= '0;
            cgs_en_q  <= 1'b0;
            ilas_en_q <= 1'b0;
            data_en_q <= 1'b0;
            low_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ilas_mf_q <= ilas_mf_d;
            cgs_en_q  <= (state_d == ST_CGS);
            ilas_en_q <= (state_d == ST_ILAS);
            data_en_q <= (state_d == ST_DATA);
            low_cnt_q <= low_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign cgs_en       = cgs_en_q;
    assign ilas_en      = ilas_en_q;
    assign data_en      = data_en_q;
    assign link_up      = data_en_q;
    assign ilas_mf      = ilas_mf_q;
    assign sync_err_cnt = err_cnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_jesd204b_dl_tx_ctrl.sv
// Bench for jesd204b_dl_tx_ctrl: a beat/phase model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_jesd204b_dl_tx_ctrl;
    import jesd204b_pkg::*;

    localparam int F  = 5;
    localparam int K  = 4;
    localparam int MF = F * K / 4;
    localparam int RB = 8;

    localparam int P_IDLE = 0;
    localparam int P_CGS  = 1;
    localparam int P_ILAS = 2;
    localparam int P_DATA = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        link_en;
    logic        sync_n;
    logic        sysref;
    logic        sysref_oneshot;
    logic        lmfc;
    logic        cgs_en;
    logic        ilas_en;
    logic        data_en;
    logic [1:0]  ilas_mf;
    logic [3:0]  eof;
    logic [3:0]  eom;
    logic        link_up;
    logic [7:0]  sync_err_cnt;
    link_state_e state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    jesd204b_dl_tx_ctrl #(
        .OCTETS_PER_FR (F),
        .FRAMES_PER_MF (K),
        .RESYNC_BEATS  (RB)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .link_en        (link_en),
        .sync_n         (sync_n),
        .sysref         (sysref),
        .sysref_oneshot (sysref_oneshot),
        .lmfc           (lmfc),
        .cgs_en         (cgs_en),
        .ilas_en        (ilas_en),
        .data_en        (data_en),
        .ilas_mf        (ilas_mf),
        .eof            (eof),
        .eom            (eom),
        .link_up        (link_up),
        .sync_err_cnt   (sync_err_cnt),
        .state_o        (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_lmfc"},    32'(lmfc),         32'd0);
        check({tag, "_cgs"},     32'(cgs_en),       32'd0);
        check({tag, "_ilas"},    32'(ilas_en),      32'd0);
        check({tag, "_data"},    32'(data_en),      32'd0);
        check({tag, "_ilas_mf"}, 32'(ilas_mf),      32'd0);
        check({tag, "_eof"},     32'(eof),          32'd0);
        check({tag, "_eom"},     32'(eom),          32'd0);
        check({tag, "_link_up"}, 32'(link_up),      32'd0);
        check({tag, "_err"},     32'(sync_err_cnt), 32'd0);
    endtask

    // ---------------- behavioural model ----------------
    // Octet position arithmetic straight from the frame definition.
    function automatic logic [3:0] exp_eof(input int beat);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ((beat * 4 + i) % F) == (F - 1);
        return r;
    endfunction

    function automatic logic [3:0] exp_eom(input int beat);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (beat * 4 + i) == (F * K - 1);
        return r;
    endfunction

    bit m_valid;
    int m_beat;
    int m_phase;
    int m_ilas_left;
    int m_low_run;
    int m_err;
    bit m_sref_prev;
    bit m_seen;

    always @(posedge clk or negedge reset_n) begin : model_step
        bit edge_s, realign;
        int nb, run, err, ph, left;
        if (!reset_n) begin
            m_valid     <= 1'b0;
            m_beat      <= 0;
            m_phase     <= P_IDLE;
            m_ilas_left <= 0;
            m_low_run   <= 0;
            m_err       <= 0;
            m_sref_prev <= 1'b0;
            m_seen      <= 1'b0;
        end else begin
            edge_s  = sysref && !m_sref_prev;
            realign = edge_s && !(sysref_oneshot && m_seen);
            nb      = realign ? 0 : (m_beat + 1) % MF;
            run     = sync_n ? 0 : m_low_run + 1;
            err     = m_err;
            if (m_phase == P_DATA && sync_n && m_low_run > 0 && m_low_run < RB && err < 255) err++;
            ph   = m_phase;
            left = m_ilas_left;
            if (!link_en) begin
                ph = P_IDLE;
            end else begin
                case (m_phase)
                    P_IDLE: ph = P_CGS;
                    P_CGS: if (sync_n && nb == 0) begin
                        ph   = P_ILAS;
                        left = 4 * MF;
                    end
                    P_ILAS: if (realign || run >= RB) begin
                        ph = P_CGS;
                    end else begin
                        left--;
                        if (left == 0) ph = P_DATA;
                    end
                    default: if (run >= RB) ph = P_CGS;
                endcase
            end
            m_valid     <= 1'b1;
            m_beat      <= nb;
            m_phase     <= ph;
            m_ilas_left <= left;
            m_low_run   <= run;
            m_err       <= err;
            m_sref_prev <= sysref;
            m_seen      <= m_seen || edge_s;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("lmfc",    32'(lmfc),         32'(m_beat == 0));
            check("eof",     32'(eof),          32'(exp_eof(m_beat)));
            check("eom",     32'(eom),          32'(exp_eom(m_beat)));
            check("cgs_en",  32'(cgs_en),       32'(m_phase == P_CGS));
            check("ilas_en", 32'(ilas_en),      32'(m_phase == P_ILAS));
            check("data_en", 32'(data_en),      32'(m_phase == P_DATA));
            check("link_up", 32'(link_up),      32'(m_phase == P_DATA));
            check("ilas_mf", 32'(ilas_mf),      (m_phase == P_ILAS) ? 32'((4 * MF - m_ilas_left) / MF) : 32'd0);
            check("err_cnt", 32'(sync_err_cnt), 32'(m_err));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_for_ilas(input string name);
        bit hit = 1'b0;
        for (int t = 0; t < 60 && !hit; t++) begin
            tick();
            hit = ilas_en;
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic wait_for_data(input string name);
        bit hit = 1'b0;
        for (int t = 0; t < 60 && !hit; t++) begin
            tick();
            hit = data_en;
        end
        check(name, 32'(hit), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] eof_tbl [5];
    int         ilas_cnt;
    bit         reached_data;

    initial begin
        eof_tbl        = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        reset_n        = 1'b0;
        link_en        = 1'b0;
        sync_n         = 1'b1;
        sysref         = 1'b0;
        sysref_oneshot = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        reset_n = 1'b1;

        // Free-running boundaries with no SYSREF: beat c after release.
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("pin_lmfc", 32'(lmfc), 32'(c % 5 == 0));
            check("pin_eof",  32'(eof),  32'(eof_tbl[c % 5]));
            check("pin_eom",  32'(eom),  (c % 5 == 4) ? 32'h8 : 32'h0);
        end

        // SYSREF realign from beat 2, then a second edge ignored in one-shot mode.
        repeat (2) tick();
        sysref = 1'b1;
        tick();
        check("sref_lmfc", 32'(lmfc), 32'd1);
        check("sref_eof",  32'(eof),  32'd0);
        sysref = 1'b0;
        repeat (3) tick();
        sysref = 1'b1;
        tick();
        check("oneshot_lmfc", 32'(lmfc), 32'd0);
        check("oneshot_eom",  32'(eom),  32'h8);
        sysref = 1'b0;

        // Bring-up: CGS while SYNC~ low, then 20 ILAS beats, then DATA.
        sync_n  = 1'b0;
        link_en = 1'b1;
        repeat (30) tick();
        check("cgs_hold", 32'(cgs_en), 32'd1);
        sync_n       = 1'b1;
        ilas_cnt     = 0;
        reached_data = 1'b0;
        for (int t = 0; t < 60 && !reached_data; t++) begin
            tick();
            if (ilas_en) begin
                if (ilas_cnt == 0) begin
                    check("ilas_first_lmfc", 32'(lmfc),    32'd1);
                    check("ilas_first_mf",   32'(ilas_mf), 32'd0);
                end
                ilas_cnt++;
            end
            reached_data = data_en;
        end
        check("ilas_len",   32'(ilas_cnt),     32'd20);
        check("reach_data", 32'(reached_data), 32'd1);
        check("link_up",    32'(link_up),      32'd1);

        // Short SYNC~ pulse counts an error; a full-length one forces CGS.
        sync_n = 1'b0;
        repeat (3) tick();
        sync_n = 1'b1;
        tick();
        check("short_err",  32'(sync_err_cnt), 32'd1);
        check("short_data", 32'(data_en),      32'd1);
        sync_n = 1'b0;
        repeat (7) tick();
        check("long_7_data", 32'(data_en), 32'd1);
        tick();
        check("long_8_cgs", 32'(cgs_en), 32'd1);
        check("long_8_err", 32'(sync_err_cnt), 32'd1);
        sync_n = 1'b1;
        wait_for_data("relink_data");

        // Error counter saturation.
        for (int p = 0; p < 300; p++) begin
            sync_n = 1'b0;
            tick();
            sync_n = 1'b1;
            tick();
        end
        check("err_sat",      32'(sync_err_cnt), 32'd255);
        check("err_sat_data", 32'(data_en),      32'd1);

        // SYSREF realign during ILAS returns to CGS.
        link_en = 1'b0;
        tick();
        check("off_cgs",  32'(cgs_en),  32'd0);
        check("off_data", 32'(data_en), 32'd0);
        link_en = 1'b1;
        wait_for_ilas("ilas_for_realign");
        repeat (2) tick();
        sysref_oneshot = 1'b0;
        sysref         = 1'b1;
        tick();
        check("realign_cgs",  32'(cgs_en),  32'd1);
        check("realign_ilas", 32'(ilas_en), 32'd0);
        check("realign_lmfc", 32'(lmfc),    32'd1);
        sysref = 1'b0;

        // link_en drop in ILAS goes straight to IDLE.
        wait_for_ilas("ilas_for_drop");
        tick();
        link_en = 1'b0;
        tick();
        check("drop_cgs",     32'(cgs_en),  32'd0);
        check("drop_ilas",    32'(ilas_en), 32'd0);
        check("drop_data",    32'(data_en), 32'd0);
        check("drop_ilas_mf", 32'(ilas_mf), 32'd0);

        // Asynchronous reset in the middle of ILAS, checked before any clock edge.
        link_en = 1'b1;
        wait_for_ilas("ilas_for_reset");
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1 check_reset_vals("async_rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
